// File: rtl/fifo_frame_drain_ctrl.sv
// fifo_frame_drain_ctrl: drains async-FIFO pixels in bursts into sequential frame-buffer addresses
module fifo_frame_drain_ctrl #(
  parameter int DW = 12,
  parameter int FRAME_PIXELS = 307200,
  parameter int BURST = 16,
  parameter int ADDR_W = 19
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic              i_enable,
  input  logic              i_frame_start,
  input  logic              i_clr_err,
  output logic              fifo_r_en,
  input  logic [DW-1:0]     fifo_o_dat,
  input  logic              fifo_r_empty,
  input  logic              fifo_r_almost_empty,
  input  logic              i_mem_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DW-1:0]     o_mem_dat,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_overrun
);
  localparam int BW = BURST > 1 ? $clog2(BURST) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [ADDR_W:0] FP_W = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W:0] BURST_W = (ADDR_W+1)'(BURST);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAIT, S_BURST, S_DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pix, pix_n;
  logic [BW-1:0] beat, beat_n;
  logic [ADDR_W:0] remaining;
  logic ovr_set;
  assign remaining = FP_W - {1'b0, pix};
  assign fifo_r_en = (state == S_BURST) & i_mem_ready & ~fifo_r_empty & i_enable;
  assign o_busy = (state == S_WAIT) || (state == S_BURST);
  assign o_frame_done = state == S_DONE;
  always_comb begin
    state_n = state;
    pix_n = pix;
    beat_n = beat;
    ovr_set = 1'b0;
    if (!i_enable) state_n = S_IDLE;
    else case (state)
      S_IDLE: state_n = S_ARMED;
      S_ARMED: if (i_frame_start) begin
        pix_n = '0;
        beat_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: if (i_frame_start) begin
        ovr_set = 1'b1;
        pix_n = '0;
        beat_n = '0;
      end else if (remaining > BURST_W ? !fifo_r_almost_empty : !fifo_r_empty) begin
        beat_n = '0;
        state_n = S_BURST;
      end
      S_BURST: if (i_frame_start) begin
        ovr_set = 1'b1;
        pix_n = '0;
        beat_n = '0;
        state_n = S_WAIT;
      end else if (fifo_r_en) begin
        pix_n = pix == LAST_PIX ? pix : pix + 1'b1;
        beat_n = beat + 1'b1;
        state_n = pix == LAST_PIX ? S_DONE : beat == LAST_BEAT ? S_WAIT : S_BURST;
      end
      S_DONE: begin
        state_n = i_frame_start ? S_WAIT : S_ARMED;
        pix_n = i_frame_start ? '0 : pix;
        beat_n = i_frame_start ? '0 : beat;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // write port lags the FIFO read by one cycle; address is the pre-increment pixel index
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state <= S_IDLE;
      pix <= '0;
      beat <= '0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_dat <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_n;
      pix <= pix_n;
      beat <= beat_n;
      o_mem_we <= fifo_r_en;
      if (fifo_r_en) begin
        o_mem_addr <= pix;
        o_mem_dat <= fifo_o_dat;
      end
      o_overrun <= ovr_set | (o_overrun & ~i_clr_err);
    end
  end
endmodule

// File: tb/tb_fifo_frame_drain_ctrl.sv
// tb_fifo_frame_drain_ctrl: FIFO model plus write scoreboard around fifo_frame_drain_ctrl
module tb_fifo_frame_drain_ctrl;
  localparam int DW = 4, FP = 40, BU = 8, AW = 6;
  logic r_clk = 0, r_rstn = 0, i_enable = 0, i_frame_start = 0, i_clr_err = 0;
  logic fifo_r_empty = 1, fifo_r_almost_empty = 1, i_mem_ready = 1;
  logic [DW-1:0] fifo_o_dat = '0;
  logic fifo_r_en, o_mem_we, o_frame_done, o_busy, o_overrun;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_dat;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {logic en, sof, clr, busy, ovr;} vec_t;
  wr_t sb[$];
  logic [DW-1:0] fq[$];
  vec_t tv[11];
  int errors = 0, checks = 0, nwr = 0, ndone = 0, exp_addr = 0, last_addr = 0, k = 0;
  int n0, n1, d0, pushed;
  bit pend = 0;

  fifo_frame_drain_ctrl #(.DW(DW), .FRAME_PIXELS(FP), .BURST(BU), .ADDR_W(AW)) dut (
    .r_clk(r_clk), .r_rstn(r_rstn), .i_enable(i_enable), .i_frame_start(i_frame_start),
    .i_clr_err(i_clr_err), .fifo_r_en(fifo_r_en), .fifo_o_dat(fifo_o_dat),
    .fifo_r_empty(fifo_r_empty), .fifo_r_almost_empty(fifo_r_almost_empty),
    .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_dat(o_mem_dat), .o_frame_done(o_frame_done), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 r_clk = ~r_clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic push(input int n);
    repeat (n) begin
      fq.push_back(DW'(k));
      k++;
    end
  endtask

  task automatic cyc();
    wr_t e;
    bit ed;
    fifo_r_empty = fq.size() == 0;
    fifo_r_almost_empty = fq.size() <= 4;
    fifo_o_dat = fq.size() > 0 ? fq[0] : '0;
    #1;
    chk("ren_legal", {31'b0, fifo_r_en & (fifo_r_empty | ~i_mem_ready | ~i_enable)}, 0);
    pend = fifo_r_en;
    if (pend) begin
      sb.push_back({AW'(exp_addr), fq.size() > 0 ? fq[0] : '0});
      exp_addr++;
    end
    if (i_frame_start && i_enable) exp_addr = 0;
    @(posedge r_clk);
    #1;
    if (pend && fq.size() > 0) fq.delete(0);
    chk("mem_we_latency", {31'b0, o_mem_we}, {31'b0, pend});
    ed = 0;
    if (o_mem_we) begin
      nwr++;
      last_addr = int'(o_mem_addr);
      chk("sb_has_entry", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mem_addr", {26'b0, o_mem_addr}, {26'b0, e.a});
        chk("mem_dat", {28'b0, o_mem_dat}, {28'b0, e.d});
        ed = e.a == AW'(FP - 1);
      end
    end
    chk("frame_done", {31'b0, o_frame_done}, {31'b0, ed});
    if (o_frame_done) ndone++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_until_done(input int budget);
    int d = ndone;
    for (int i = 0; i < budget && ndone == d; i++) cyc();
  endtask

  task automatic pulse_sof();
    i_frame_start = 1;
    cyc();
    i_frame_start = 0;
  endtask

  task automatic chk_all_zero(input string n);
    chk(n, {23'b0, fifo_r_en, o_mem_we, o_frame_done, o_busy, o_overrun, 3'b0},
        0);
    chk({n, "_addr_dat"}, {22'b0, o_mem_addr, o_mem_dat}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    tv[0]  = '{0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 0, 0};
    tv[2]  = '{1, 0, 0, 0, 0};
    tv[3]  = '{1, 1, 0, 1, 0};
    tv[4]  = '{1, 0, 0, 1, 0};
    tv[5]  = '{1, 1, 0, 1, 1};
    tv[6]  = '{1, 0, 1, 1, 0};
    tv[7]  = '{1, 1, 1, 1, 1};
    tv[8]  = '{1, 0, 1, 1, 0};
    tv[9]  = '{0, 0, 0, 0, 0};
    tv[10] = '{1, 0, 0, 0, 0};
    repeat (2) @(posedge r_clk);
    #1;
    chk_all_zero("reset_init");
    r_rstn = 1;
    for (int i = 0; i < 11; i++) begin
      i_enable = tv[i].en;
      i_frame_start = tv[i].sof;
      i_clr_err = tv[i].clr;
      cyc();
      chk("tbl_busy", {31'b0, o_busy}, {31'b0, tv[i].busy});
      chk("tbl_ovr", {31'b0, o_overrun}, {31'b0, tv[i].ovr});
    end
    i_frame_start = 0;
    i_clr_err = 0;
    // full frame from a preloaded FIFO
    n0 = nwr; d0 = ndone;
    push(40);
    pulse_sof();
    run_until_done(300);
    chk("a_writes", nwr - n0, 40);
    chk("a_done", ndone - d0, 1);
    chk("a_last_addr", last_addr, FP - 1);
    run(2);
    chk("a_armed_busy", {31'b0, o_busy}, 0);
    chk("a_sb_drained", sb.size(), 0);
    // sparse FIFO and toggling grant
    n0 = nwr; d0 = ndone; pushed = 0;
    pulse_sof();
    for (int i = 0; i < 800 && ndone == d0; i++) begin
      i_mem_ready = (i % 2) == 0;
      if (i % 3 == 0 && pushed < 40) begin
        push(1);
        pushed++;
      end
      cyc();
    end
    i_mem_ready = 1;
    chk("b_writes", nwr - n0, 40);
    chk("b_done", ndone - d0, 1);
    chk("b_last_addr", last_addr, FP - 1);
    // tail flush with almost_empty set
    n0 = nwr; d0 = ndone;
    pulse_sof();
    push(32);
    run(100);
    chk("c_writes_32", nwr - n0, 32);
    push(3);
    run(30);
    chk("c_tail_3", nwr - n0, 35);
    chk("c_no_done_yet", ndone - d0, 0);
    push(5);
    run_until_done(60);
    chk("c_done", ndone - d0, 1);
    chk("c_last_addr", last_addr, FP - 1);
    chk("c_writes", nwr - n0, 40);
    // overrun and error clear
    n0 = nwr;
    pulse_sof();
    push(30);
    for (int i = 0; i < 200 && exp_addr < 20; i++) cyc();
    chk("d_pre_writes", nwr - n0, 20);
    chk("d_pre_ovr", {31'b0, o_overrun}, 0);
    i_mem_ready = 0;
    pulse_sof();
    chk("d_ovr_set", {31'b0, o_overrun}, 1);
    i_mem_ready = 1;
    n1 = nwr;
    for (int i = 0; i < 20 && nwr == n1; i++) cyc();
    chk("d_restart_addr", last_addr, 0);
    pulse_sof();
    chk("d_sof_xfer_we", {31'b0, o_mem_we}, 1);
    chk("d_sof_xfer_addr", last_addr, 1);
    n1 = nwr;
    for (int i = 0; i < 20 && nwr == n1; i++) cyc();
    chk("d_restart2_addr", last_addr, 0);
    i_clr_err = 1; cyc(); i_clr_err = 0;
    chk("d_clr", {31'b0, o_overrun}, 0);
    i_clr_err = 1; i_frame_start = 1; cyc(); i_clr_err = 0; i_frame_start = 0;
    chk("d_set_beats_clr", {31'b0, o_overrun}, 1);
    i_clr_err = 1; cyc(); i_clr_err = 0;
    chk("d_clr2", {31'b0, o_overrun}, 0);
    i_enable = 0;
    run(3);
    chk("d_sb_drained", sb.size(), 0);
    fq.delete();
    i_enable = 1;
    cyc();
    // enable drop after pixel 12 is read
    n0 = nwr; d0 = ndone;
    pulse_sof();
    push(40);
    for (int i = 0; i < 200 && exp_addr < 13; i++) cyc();
    chk("e_inflight_we", {31'b0, o_mem_we}, 1);
    chk("e_inflight_addr", {26'b0, o_mem_addr}, 12);
    i_enable = 0;
    #1;
    chk("e_ren_drop", {31'b0, fifo_r_en}, 0);
    n1 = nwr;
    run(20);
    chk("e_no_writes_disabled", nwr - n1, 0);
    i_enable = 1;
    run(10);
    chk("e_no_writes_no_sof", nwr - n1, 0);
    pulse_sof();
    push(13);
    run_until_done(300);
    chk("e_resume_writes", nwr - n1, 40);
    chk("e_done", ndone - d0, 1);
    chk("e_last_addr", last_addr, FP - 1);
    // asynchronous reset mid-burst
    pulse_sof();
    push(40);
    for (int i = 0; i < 100 && exp_addr < 5; i++) cyc();
    pulse_sof();
    n1 = nwr;
    for (int i = 0; i < 50 && nwr < n1 + 3; i++) cyc();
    chk("f_pre_busy", {31'b0, o_busy}, 1);
    chk("f_pre_ovr", {31'b0, o_overrun}, 1);
    #3;
    r_rstn = 0;
    #1;
    chk_all_zero("f_async_reset");
    sb.delete();
    pend = 0;
    repeat (2) @(posedge r_clk);
    #1;
    r_rstn = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("f_ren_idle", {31'b0, fifo_r_en}, 0);
      chk("f_busy_idle", {31'b0, o_busy}, 0);
      chk("f_ovr_idle", {31'b0, o_overrun}, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
